// File: rtl/stopwatch_timer.sv
// stopwatch_timer
// mm:ss time-keeping block. It runs as an up-counting stopwatch or as a
// down-counting timer with an expiry alarm, and it has an adjust mode that
// steps the selected field up or down.
//
// Optional feature: define STOPWATCH_LAP_EN to enable the lap-hold display
// and clear-on-lap behaviour. In the default build btn_lap is ignored and
// lap_hold is tied low.
//
// Parameters:
//   MIN_MAX    highest minute value (1..99). Minutes wrap to 00 after it.
//   RESET_RUN  state after reset: 1 = RUNNING, 0 = PAUSED.
//
// Ports:
//   clk_100mhz      system clock
//   rst             synchronous, active-high reset
//   tick_count      1 Hz counting enable (1-cycle pulse)
//   tick_adj        2 Hz adjust enable (1-cycle pulse)
//   btn_pause       debounced pause button level
//   btn_lap         debounced lap/clear button level
//   sw_sel          adjust field select (1 = seconds, 0 = minutes)
//   sw_adj          adjust mode switch
//   sw_down         count down / adjust decrement
//   bcd_*           displayed digits, mm:ss in BCD
//   is_adj          high in either adjust state
//   is_sel_sec      mirrors sw_sel
//   is_running      high in RUNNING or ADJ_RUNNING
//   alarm           high only in EXPIRED
//   lap_hold        display is frozen on the lap value
module stopwatch_timer #(
   parameter int MIN_MAX   = 59,
   parameter bit RESET_RUN = 1'b1
) (
   input  logic       clk_100mhz,
   input  logic       rst,
   input  logic       tick_count,
   input  logic       tick_adj,
   input  logic       btn_pause,
   input  logic       btn_lap,
   input  logic       sw_sel,
   input  logic       sw_adj,
   input  logic       sw_down,
   output logic [3:0] bcd_min_tens,
   output logic [3:0] bcd_min_ones,
   output logic [3:0] bcd_sec_tens,
   output logic [3:0] bcd_sec_ones,
   output logic       is_adj,
   output logic       is_sel_sec,
   output logic       is_running,
   output logic       alarm,
   output logic       lap_hold
);

   typedef enum logic [2:0] {
      PAUSED,
      RUNNING,
      ADJ_PAUSED,
      ADJ_RUNNING,
      EXPIRED
   } state_t;

   localparam logic [3:0] MAX_TENS    = 4'(MIN_MAX / 10);
   localparam logic [3:0] MAX_ONES    = 4'(MIN_MAX % 10);
   localparam logic [7:0] MIN_TOP     = {MAX_TENS, MAX_ONES};
   localparam state_t     RESET_STATE = RESET_RUN ? RUNNING : PAUSED;

   state_t     state_q, state_d;
   logic [7:0] min_q, min_d;
   logic [7:0] sec_q, sec_d;
   logic       pause_q;
   logic       pause_press;
   logic       live_zero, live_one;
   logic       enter_adj;

   // Field steppers, each working on a {tens, ones} BCD byte.
   function automatic logic [7:0] sec_inc(input logic [7:0] v);
      if (v[3:0] != 4'd9)      return {v[7:4], v[3:0] + 4'd1};
      else if (v[7:4] != 4'd5) return {v[7:4] + 4'd1, 4'd0};
      else                     return 8'h00;
   endfunction

   function automatic logic [7:0] sec_dec(input logic [7:0] v);
      if (v[3:0] != 4'd0)      return {v[7:4], v[3:0] - 4'd1};
      else if (v[7:4] != 4'd0) return {v[7:4] - 4'd1, 4'd9};
      else                     return 8'h59;
   endfunction

   function automatic logic [7:0] min_inc(input logic [7:0] v);
      if (v == MIN_TOP)        return 8'h00;
      else if (v[3:0] != 4'd9) return {v[7:4], v[3:0] + 4'd1};
      else                     return {v[7:4] + 4'd1, 4'd0};
   endfunction

   function automatic logic [7:0] min_dec(input logic [7:0] v);
      if (v == 8'h00)          return MIN_TOP;
      else if (v[3:0] != 4'd0) return {v[7:4], v[3:0] - 4'd1};
      else                     return {v[7:4] - 4'd1, 4'd9};
   endfunction

   // The button history samples even during reset, so a button held
   // through reset release is not seen as a fresh press.
   always_ff @(posedge clk_100mhz) begin
      pause_q <= btn_pause;
   end

   assign pause_press = btn_pause & ~pause_q;
   assign live_zero   = (min_q == 8'h00) && (sec_q == 8'h00);
   assign live_one    = (min_q == 8'h00) && (sec_q == 8'h01);

`ifdef STOPWATCH_LAP_EN
   logic        lap_btn_q;
   logic        lap_press;
   logic        lap_hold_q, lap_hold_d;
   logic [15:0] lap_q, lap_d;

   always_ff @(posedge clk_100mhz) begin
      lap_btn_q <= btn_lap;
   end

   assign lap_press = btn_lap & ~lap_btn_q;
`endif

   // Next-state and next-time logic. The lap handling runs after the state
   // transitions so that it sees the pre-tick live time, and entering an
   // adjust state always has the final word on lap_hold.
   always_comb begin
      state_d   = state_q;
      min_d     = min_q;
      sec_d     = sec_q;
      enter_adj = 1'b0;
`ifdef STOPWATCH_LAP_EN
      lap_hold_d = lap_hold_q;
      lap_d      = lap_q;
`endif
      case (state_q)
         PAUSED: begin
            if (pause_press) begin
               state_d = RUNNING;
            end else if (sw_adj) begin
               state_d   = ADJ_PAUSED;
               enter_adj = 1'b1;
            end
         end
         RUNNING: begin
            if (pause_press) begin
               state_d = PAUSED;
            end else if (sw_adj) begin
               state_d   = ADJ_RUNNING;
               enter_adj = 1'b1;
            end else if (tick_count) begin
               if (!sw_down) begin
                  sec_d = sec_inc(sec_q);
                  if (sec_q == 8'h59) min_d = min_inc(min_q);
               end else if (live_zero) begin
                  state_d = EXPIRED;
               end else begin
                  sec_d = sec_dec(sec_q);
                  if (sec_q == 8'h00) min_d = min_dec(min_q);
                  if (live_one) state_d = EXPIRED;
               end
            end
         end
         ADJ_PAUSED, ADJ_RUNNING: begin
            if (!sw_adj) begin
               state_d = (state_q == ADJ_PAUSED) ? PAUSED : RUNNING;
            end else if (tick_adj) begin
               if (sw_sel) sec_d = sw_down ? sec_dec(sec_q) : sec_inc(sec_q);
               else        min_d = sw_down ? min_dec(min_q) : min_inc(min_q);
            end
         end
         EXPIRED: begin
            if (pause_press) begin
               state_d = PAUSED;
            end else if (sw_adj) begin
               state_d   = ADJ_PAUSED;
               enter_adj = 1'b1;
            end
         end
         default: state_d = RESET_STATE;
      endcase
`ifdef STOPWATCH_LAP_EN
      if (lap_press) begin
         if (lap_hold_q) begin
            lap_hold_d = 1'b0;
         end else if (state_q == RUNNING) begin
            lap_d      = {min_q, sec_q};
            lap_hold_d = 1'b1;
         end else if (state_q == PAUSED) begin
            min_d = 8'h00;
            sec_d = 8'h00;
         end
      end
      if (enter_adj) lap_hold_d = 1'b0;
`endif
   end

   // State, time and lap registers.
   always_ff @(posedge clk_100mhz) begin
      if (rst) begin
         state_q <= RESET_STATE;
         min_q   <= 8'h00;
         sec_q   <= 8'h00;
`ifdef STOPWATCH_LAP_EN
         lap_hold_q <= 1'b0;
         lap_q      <= 16'h0000;
`endif
      end else begin
         state_q <= state_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
`ifdef STOPWATCH_LAP_EN
         lap_hold_q <= lap_hold_d;
         lap_q      <= lap_d;
`endif
      end
   end

`ifdef STOPWATCH_LAP_EN
   assign lap_hold = lap_hold_q;
   assign {bcd_min_tens, bcd_min_ones, bcd_sec_tens, bcd_sec_ones} =
      lap_hold_q ? lap_q : {min_q, sec_q};
`else
   logic unused_lap;
   assign unused_lap = btn_lap ^ enter_adj;
   assign lap_hold   = 1'b0;
   assign {bcd_min_tens, bcd_min_ones, bcd_sec_tens, bcd_sec_ones} = {min_q, sec_q};
`endif

   assign is_adj     = (state_q == ADJ_PAUSED) || (state_q == ADJ_RUNNING);
   assign is_sel_sec = sw_sel;
   assign is_running = (state_q == RUNNING) || (state_q == ADJ_RUNNING);
   assign alarm      = (state_q == EXPIRED);

endmodule

// File: tb/tb_stopwatch_timer.sv
// tb_stopwatch_timer
// Three instances share the stimulus: MIN_MAX=59 running after reset,
// MIN_MAX=9 running after reset, and MIN_MAX=59 paused after reset. A
// reference model keeps the time as whole seconds and steps it with plain
// modular arithmetic.
module tb_stopwatch_timer;

   logic clk_100mhz = 1'b0;
   always #5 clk_100mhz = ~clk_100mhz;

   logic rst, tick_count, tick_adj, btn_pause, btn_lap, sw_sel, sw_adj, sw_down;

   logic [3:0] mt [3];
   logic [3:0] mo [3];
   logic [3:0] st [3];
   logic [3:0] so [3];
   logic       adj_o [3];
   logic       sel_o [3];
   logic       run_o [3];
   logic       alarm_o [3];
   logic       hold_o [3];
   logic [15:0] disp [3];
   logic [4:0]  stat [3];

   for (genvar g = 0; g < 3; g++) begin : g_pack
      assign disp[g] = {mt[g], mo[g], st[g], so[g]};
      assign stat[g] = {adj_o[g], sel_o[g], run_o[g], alarm_o[g], hold_o[g]};
   end

   stopwatch_timer #(.MIN_MAX(59), .RESET_RUN(1'b1)) dut (
      .clk_100mhz(clk_100mhz), .rst(rst), .tick_count(tick_count), .tick_adj(tick_adj),
      .btn_pause(btn_pause), .btn_lap(btn_lap), .sw_sel(sw_sel), .sw_adj(sw_adj),
      .sw_down(sw_down), .bcd_min_tens(mt[0]), .bcd_min_ones(mo[0]),
      .bcd_sec_tens(st[0]), .bcd_sec_ones(so[0]), .is_adj(adj_o[0]),
      .is_sel_sec(sel_o[0]), .is_running(run_o[0]), .alarm(alarm_o[0]),
      .lap_hold(hold_o[0]));

   stopwatch_timer #(.MIN_MAX(9), .RESET_RUN(1'b1)) dut9 (
      .clk_100mhz(clk_100mhz), .rst(rst), .tick_count(tick_count), .tick_adj(tick_adj),
      .btn_pause(btn_pause), .btn_lap(btn_lap), .sw_sel(sw_sel), .sw_adj(sw_adj),
      .sw_down(sw_down), .bcd_min_tens(mt[1]), .bcd_min_ones(mo[1]),
      .bcd_sec_tens(st[1]), .bcd_sec_ones(so[1]), .is_adj(adj_o[1]),
      .is_sel_sec(sel_o[1]), .is_running(run_o[1]), .alarm(alarm_o[1]),
      .lap_hold(hold_o[1]));

   stopwatch_timer #(.MIN_MAX(59), .RESET_RUN(1'b0)) dutp (
      .clk_100mhz(clk_100mhz), .rst(rst), .tick_count(tick_count), .tick_adj(tick_adj),
      .btn_pause(btn_pause), .btn_lap(btn_lap), .sw_sel(sw_sel), .sw_adj(sw_adj),
      .sw_down(sw_down), .bcd_min_tens(mt[2]), .bcd_min_ones(mo[2]),
      .bcd_sec_tens(st[2]), .bcd_sec_ones(so[2]), .is_adj(adj_o[2]),
      .is_sel_sec(sel_o[2]), .is_running(run_o[2]), .alarm(alarm_o[2]),
      .lap_hold(hold_o[2]));

   // Reference model
   localparam int M_PAUSED = 0, M_RUN = 1, M_ADJP = 2, M_ADJR = 3, M_EXP = 4;
   int mx [3];
   int rr [3];
   int m_min [3];
   int m_sec [3];
   int m_st [3];
   int m_hold [3];
   int m_lap [3];
   bit prev_p = 1'b0;
   bit prev_l = 1'b0;

   int errors = 0;
   int checks = 0;

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_update();
      bit pp, lp, entry;
      int t, pre, span, nst;
      pp = btn_pause & ~prev_p;
      lp = btn_lap & ~prev_l;
      for (int i = 0; i < 3; i++) begin
         if (rst) begin
            m_min[i] = 0; m_sec[i] = 0; m_hold[i] = 0; m_lap[i] = 0;
            m_st[i]  = rr[i] ? M_RUN : M_PAUSED;
         end else begin
            span  = (mx[i] + 1) * 60;
            t     = m_min[i] * 60 + m_sec[i];
            pre   = t;
            nst   = m_st[i];
            entry = 1'b0;
            case (m_st[i])
               M_PAUSED: begin
                  if (pp) nst = M_RUN;
                  else if (sw_adj) begin nst = M_ADJP; entry = 1'b1; end
               end
               M_RUN: begin
                  if (pp) nst = M_PAUSED;
                  else if (sw_adj) begin nst = M_ADJR; entry = 1'b1; end
                  else if (tick_count) begin
                     if (!sw_down) t = (t + 1) % span;
                     else if (t == 0) nst = M_EXP;
                     else begin
                        t = t - 1;
                        if (t == 0) nst = M_EXP;
                     end
                     m_min[i] = t / 60;
                     m_sec[i] = t % 60;
                  end
               end
               M_ADJP, M_ADJR: begin
                  if (!sw_adj) nst = (m_st[i] == M_ADJP) ? M_PAUSED : M_RUN;
                  else if (tick_adj) begin
                     if (sw_sel) m_sec[i] = (m_sec[i] + (sw_down ? 59 : 1)) % 60;
                     else        m_min[i] = (m_min[i] + (sw_down ? mx[i] : 1)) % (mx[i] + 1);
                  end
               end
               default: begin
                  if (pp) nst = M_PAUSED;
                  else if (sw_adj) begin nst = M_ADJP; entry = 1'b1; end
               end
            endcase
`ifdef STOPWATCH_LAP_EN
            if (lp) begin
               if (m_hold[i] != 0) m_hold[i] = 0;
               else if (m_st[i] == M_RUN) begin m_lap[i] = pre; m_hold[i] = 1; end
               else if (m_st[i] == M_PAUSED) begin m_min[i] = 0; m_sec[i] = 0; end
            end
`else
            if (lp) pre = 0;
`endif
            if (entry) m_hold[i] = 0;
            m_st[i] = nst;
         end
      end
      prev_p = btn_pause;
      prev_l = btn_lap;
   endtask

   function automatic logic [15:0] exp_disp(input int i);
      int v, mm, ss;
      v  = (m_hold[i] != 0) ? m_lap[i] : m_min[i] * 60 + m_sec[i];
      mm = v / 60;
      ss = v % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic logic [4:0] exp_stat(input int i);
      return {m_st[i] == M_ADJP || m_st[i] == M_ADJR, sw_sel,
              m_st[i] == M_RUN || m_st[i] == M_ADJR, m_st[i] == M_EXP, m_hold[i] != 0};
   endfunction

   task automatic step();
      model_update();
      @(posedge clk_100mhz);
      #1;
   endtask

   task automatic pulse_count(input int n);
      for (int k = 0; k < n; k++) begin
         tick_count = 1'b1; step();
         tick_count = 1'b0; step();
      end
   endtask

   task automatic pulse_adj(input int n);
      for (int k = 0; k < n; k++) begin
         tick_adj = 1'b1; step();
         tick_adj = 1'b0; step();
      end
   endtask

   task automatic press_pause();
      btn_pause = 1'b1; step();
      btn_pause = 1'b0; step();
   endtask

   task automatic press_lap();
      btn_lap = 1'b1; step();
      btn_lap = 1'b0; step();
   endtask

   task automatic test_reset();
      rst = 1'b1; step(); step();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({disp[i], stat[i]} !== {exp_disp(i), exp_stat(i)}) begin
            errors++;
            $display("[TB] FAIL reset inst%0d: got %h/%b required %h/%b", i, disp[i], stat[i], exp_disp(i), exp_stat(i));
         end
      end
      checks++;
      if ({disp[0], stat[0], disp[2], stat[2]} !== {16'h0000, 5'b00100, 16'h0000, 5'b00000}) begin
         errors++;
         $display("[TB] FAIL reset_const: got %h/%b %h/%b", disp[0], stat[0], disp[2], stat[2]);
      end
   endtask

   task automatic test_count_up();
      sw_down = 1'b0;
      pulse_count(60);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({disp[i], stat[i]} !== {exp_disp(i), exp_stat(i)}) begin
            errors++;
            $display("[TB] FAIL count_up inst%0d: got %h/%b required %h/%b", i, disp[i], stat[i], exp_disp(i), exp_stat(i));
         end
      end
      checks++;
      if ({disp[0], stat[0], disp[1]} !== {16'h0100, 5'b00100, 16'h0100}) begin
         errors++;
         $display("[TB] FAIL count_up_const: got %h/%b %h required 0100/00100 0100", disp[0], stat[0], disp[1]);
      end
   endtask

   task automatic test_count_down();
      sw_down = 1'b1;
      pulse_count(1);
      checks++;
      if (disp[0] !== 16'h0059 || disp[0] !== exp_disp(0)) begin
         errors++;
         $display("[TB] FAIL down_first: got %h required 0059", disp[0]);
      end
      pulse_count(59);
      checks++;
      if ({disp[0], stat[0], disp[1], stat[1]} !== {16'h0000, 5'b00010, 16'h0000, 5'b00010}) begin
         errors++;
         $display("[TB] FAIL down_expire: got %h/%b %h/%b required 0000/00010", disp[0], stat[0], disp[1], stat[1]);
      end
      pulse_count(3);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({disp[i], stat[i]} !== {exp_disp(i), exp_stat(i)}) begin
            errors++;
            $display("[TB] FAIL expired_hold inst%0d: got %h/%b required %h/%b", i, disp[i], stat[i], exp_disp(i), exp_stat(i));
         end
      end
      press_pause();
      checks++;
      if ({disp[0], stat[0]} !== {16'h0000, 5'b00000} || stat[0] !== exp_stat(0)) begin
         errors++;
         $display("[TB] FAIL expired_exit: got %h/%b required 0000/00000", disp[0], stat[0]);
      end
   endtask

   task automatic test_adjust();
      press_pause();
      sw_sel = 1'b0;
      sw_adj = 1'b1; step();
      pulse_adj(1);
      checks++;
      if ({disp[0], disp[1], stat[0]} !== {16'h5900, 16'h0900, 5'b10100}) begin
         errors++;
         $display("[TB] FAIL adj_min: got %h %h/%b required 5900 0900/10100", disp[0], disp[1], stat[0]);
      end
      sw_sel = 1'b1;
      pulse_adj(2);
      checks++;
      if ({disp[0], disp[1], stat[0]} !== {16'h5958, 16'h0958, 5'b11100}) begin
         errors++;
         $display("[TB] FAIL adj_sec: got %h %h/%b required 5958 0958/11100", disp[0], disp[1], stat[0]);
      end
      sw_adj = 1'b0; step();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({disp[i], stat[i]} !== {exp_disp(i), exp_stat(i)}) begin
            errors++;
            $display("[TB] FAIL adj_exit inst%0d: got %h/%b required %h/%b", i, disp[i], stat[i], exp_disp(i), exp_stat(i));
         end
      end
   endtask

   task automatic test_wrap();
      sw_down = 1'b0;
      pulse_count(1);
      checks++;
      if ({disp[0], disp[1]} !== {16'h5959, 16'h0959}) begin
         errors++;
         $display("[TB] FAIL wrap_top: got %h %h required 5959 0959", disp[0], disp[1]);
      end
      pulse_count(1);
      checks++;
      if ({disp[0], disp[1], stat[0]} !== {16'h0000, 16'h0000, 5'b01100}) begin
         errors++;
         $display("[TB] FAIL wrap_zero: got %h %h/%b required 0000 0000/01100", disp[0], disp[1], stat[0]);
      end
   endtask

   task automatic test_back_to_back();
      pulse_count(5);
      btn_pause = 1'b1; tick_count = 1'b1; step();
      tick_count = 1'b0; step();
      checks++;
      if ({disp[0], stat[0]} !== {16'h0005, 5'b01000}) begin
         errors++;
         $display("[TB] FAIL pause_tick: got %h/%b required 0005/01000", disp[0], stat[0]);
      end
      rst = 1'b1; step(); step();
      rst = 1'b0; step(); step();
      checks++;
      if ({stat[0], stat[2]} !== {5'b01100, 5'b01000}) begin
         errors++;
         $display("[TB] FAIL held_reset: got %b %b required 01100 01000", stat[0], stat[2]);
      end
      btn_pause = 1'b0; step();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({disp[i], stat[i]} !== {exp_disp(i), exp_stat(i)}) begin
            errors++;
            $display("[TB] FAIL held_release inst%0d: got %h/%b required %h/%b", i, disp[i], stat[i], exp_disp(i), exp_stat(i));
         end
      end
   endtask

   task automatic test_lap();
      sw_down = 1'b0;
`ifdef STOPWATCH_LAP_EN
      pulse_count(12);
      press_lap();
      pulse_count(3);
      checks++;
      if ({disp[0], hold_o[0]} !== {16'h0012, 1'b1}) begin
         errors++;
         $display("[TB] FAIL lap_hold: got %h/%b required 0012/1", disp[0], hold_o[0]);
      end
      press_lap();
      checks++;
      if ({disp[0], hold_o[0]} !== {16'h0015, 1'b0}) begin
         errors++;
         $display("[TB] FAIL lap_release: got %h/%b required 0015/0", disp[0], hold_o[0]);
      end
      press_pause();
      press_lap();
      checks++;
      if (disp[0] !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL lap_clear: got %h required 0000", disp[0]);
      end
`else
      pulse_count(3);
      press_lap();
      checks++;
      if ({disp[0], hold_o[0]} !== {16'h0003, 1'b0}) begin
         errors++;
         $display("[TB] FAIL lap_ignored: got %h/%b required 0003/0", disp[0], hold_o[0]);
      end
      press_pause();
      press_lap();
      checks++;
      if (disp[0] !== 16'h0003) begin
         errors++;
         $display("[TB] FAIL lap_no_clear: got %h required 0003", disp[0]);
      end
`endif
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({disp[i], stat[i]} !== {exp_disp(i), exp_stat(i)}) begin
            errors++;
            $display("[TB] FAIL lap_model inst%0d: got %h/%b required %h/%b", i, disp[i], stat[i], exp_disp(i), exp_stat(i));
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         tick_count = ($urandom % 3) == 0;
         tick_adj   = ($urandom % 4) == 0;
         if ($urandom % 12 == 0) btn_pause = ~btn_pause;
         if ($urandom % 12 == 0) btn_lap   = ~btn_lap;
         if ($urandom % 10 == 0) sw_sel    = ~sw_sel;
         if ($urandom % 40 == 0) sw_adj    = ~sw_adj;
         if ($urandom % 40 == 0) sw_down   = ~sw_down;
         rst = ($urandom % 400) == 0;
         step();
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({disp[i], stat[i]} !== {exp_disp(i), exp_stat(i)}) begin
               errors++;
               $display("[TB] FAIL random cycle %0d inst%0d: got %h/%b required %h/%b", n, i, disp[i], stat[i], exp_disp(i), exp_stat(i));
            end
         end
      end
   endtask

   initial begin
      mx[0] = 59; mx[1] = 9;  mx[2] = 59;
      rr[0] = 1;  rr[1] = 1;  rr[2] = 0;
      for (int i = 0; i < 3; i++) begin
         m_min[i] = 0; m_sec[i] = 0; m_st[i] = M_PAUSED; m_hold[i] = 0; m_lap[i] = 0;
      end
      rst = 1'b1; tick_count = 1'b0; tick_adj = 1'b0; btn_pause = 1'b0; btn_lap = 1'b0;
      sw_sel = 1'b0; sw_adj = 1'b0; sw_down = 1'b0;
      test_reset();
      test_count_up();
      test_count_down();
      test_adjust();
      test_wrap();
      test_back_to_back();
      test_lap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
